ntt_stage_controller: RTL

Sequences one 512-point mixed-radix NTT or INTT pass by driving the twiddle-factor address generator's conf, k and p inputs, stage by stage. Accepts a start pulse and a mode bit, and walks the four stages in mode-dependent order. Per stage, steps the twiddle index k at a stage-dependent hold rate, inserts a pipeline-drain gap between stages, and reports busy and done. Sits between the top-level NTT control and the twiddle address generator / butterfly array.

---
 rtl/ntt_stage_controller_pkg.sv | 38 +++
 rtl/ntt_stage_controller_stage_k_counter.sv | 38 +++
 rtl/ntt_stage_controller.sv | 96 +++++++++
 3 files changed

// File: rtl/ntt_stage_controller_pkg.sv
// Shared types and stage tables for the NTT/INTT stage sequencer.
// Tables are indexed by the stage level p.
package ntt_stage_controller_pkg;

    localparam int STAGE_CYCLES = 64;

    typedef enum logic [3:0] {
        CONF_IDLE    = 4'b0000,
        CONF_NTT_S0  = 4'b0001,
        CONF_NTT_S1  = 4'b0010,
        CONF_NTT_S2  = 4'b0011,
        CONF_NTT_S3  = 4'b0100,
        CONF_INTT_S0 = 4'b0101,
        CONF_INTT_S1 = 4'b0110,
        CONF_INTT_S2 = 4'b0111,
        CONF_INTT_S3 = 4'b1000
    } conf_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_GAP,
        ST_FIN
    } state_t;

    // Index = p; every row multiplies out to STAGE_CYCLES.
    localparam logic [4:0] K_LAST [4] = '{5'd31, 5'd31, 5'd7, 5'd1};
    localparam logic [5:0] HOLD   [4] = '{6'd2, 6'd2, 6'd8, 6'd32};

    function automatic conf_t stage_conf(input logic mode, input logic [1:0] s);
        return conf_t'(mode ? 4'(s) + 4'd5 : 4'(s) + 4'd1);
    endfunction

    function automatic logic [1:0] stage_p(input logic mode, input logic [1:0] s);
        return mode ? s : 2'd3 - s;
    endfunction

endpackage

// File: rtl/ntt_stage_controller_stage_k_counter.sv
// Twiddle index counter: steps k at the hold rate of level p and
// flags the final valid cycle of the stage.
module ntt_stage_controller_stage_k_counter
    import ntt_stage_controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       en,
    input  logic [1:0] p,
    output logic [4:0] k,
    output logic       stage_last
);

    logic [4:0] hold_cnt;
    logic       hold_end;

    assign hold_end   = hold_cnt == 5'(HOLD[p] - 6'd1);
    assign stage_last = en && hold_end && (k == K_LAST[p]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
            k        <= '0;
        end else if (clear || stage_last) begin
            hold_cnt <= '0;
            k        <= '0;
        end else if (en) begin
            if (hold_end) begin
                hold_cnt <= '0;
                k        <= k + 5'd1;
            end else begin
                hold_cnt <= hold_cnt + 5'd1;
            end
        end
    end

endmodule

// File: rtl/ntt_stage_controller.sv
// Sequences the four stages of one 512-point NTT/INTT pass, driving
// conf/k/p to the twiddle address generator with drain gaps between.
module ntt_stage_controller
    import ntt_stage_controller_pkg::*;
#(
    parameter int GAP = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mode,
    output logic [3:0] conf,
    output logic [4:0] k,
    output logic [1:0] p,
    output logic       valid,
    output logic       busy,
    output logic       done
);

    state_t     state;
    logic [1:0] s_idx;
    logic [3:0] gap_cnt;
    logic       mode_q;
    logic       stage_last;

    ntt_stage_controller_stage_k_counter u_stage_k_counter (
        .clk        (clk),
        .rst        (rst),
        .clear      (state == ST_IDLE),
        .en         (state == ST_RUN),
        .p          (p),
        .k          (k),
        .stage_last (stage_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            s_idx   <= '0;
            gap_cnt <= '0;
            mode_q  <= 1'b0;
            conf    <= CONF_IDLE;
            p       <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state   <= ST_RUN;
                        mode_q  <= mode;
                        s_idx   <= '0;
                        gap_cnt <= '0;
                        conf    <= stage_conf(mode, 2'd0);
                        p       <= stage_p(mode, 2'd0);
                        valid   <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (stage_last) begin
                        state   <= ST_GAP;
                        gap_cnt <= '0;
                        valid   <= 1'b0;
                    end
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt + 4'd1;
                    if (gap_cnt == 4'(GAP - 1)) begin
                        if (s_idx == 2'd3) begin
                            state <= ST_FIN;
                            conf  <= CONF_IDLE;
                            p     <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                            s_idx <= s_idx + 2'd1;
                            conf  <= stage_conf(mode_q, s_idx + 2'd1);
                            p     <= stage_p(mode_q, s_idx + 2'd1);
                            valid <= 1'b1;
                        end
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
